// File: rtl/gcn_pkg.sv
// GCN aggregation shared definitions.
// Default sizes and the aggregation FSM state type.
package gcn_pkg;

  localparam int FEATURE_ROWS_D      = 6;
  localparam int WEIGHT_COLS_D       = 3;
  localparam int DOT_PROD_WIDTH_D    = 16;
  localparam int COO_NUM_OF_COLS_D   = 6;
  localparam int COO_NUM_OF_ROWS_D   = 2;
  localparam int MAX_ADDRESS_WIDTH_D = 2;

  typedef enum logic [1:0] {
    IDLE,
    AGGREGATE,
    ARGMAX,
    DONE
  } state_t;

endpackage

// File: rtl/argmax_unit.sv
// Combinational argmax over one accumulator row.
// Strict compare keeps the lowest index on ties.
module argmax_unit #(
  parameter int WEIGHT_COLS       = 3,
  parameter int AGG_WIDTH         = 19,
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic [WEIGHT_COLS-1:0][AGG_WIDTH-1:0] vals_i,
  output logic [MAX_ADDRESS_WIDTH-1:0]          idx_o
);

  logic [AGG_WIDTH-1:0] best;

  always_comb begin
    best  = vals_i[0];
    idx_o = '0;
    for (int i = 1; i < WEIGHT_COLS; i++) begin
      if (vals_i[i] > best) begin
        best  = vals_i[i];
        idx_o = MAX_ADDRESS_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/coo_aggregation.sv
// COO edge-list neighbour aggregation followed by
// a per-node argmax over the class accumulators.
module coo_aggregation
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS      = FEATURE_ROWS_D,
  parameter int WEIGHT_COLS       = WEIGHT_COLS_D,
  parameter int DOT_PROD_WIDTH    = DOT_PROD_WIDTH_D,
  parameter int COO_NUM_OF_COLS   = COO_NUM_OF_COLS_D,
  parameter int COO_NUM_OF_ROWS   = COO_NUM_OF_ROWS_D,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int MAX_ADDRESS_WIDTH = MAX_ADDRESS_WIDTH_D,
  parameter int AGG_WIDTH         =
    DOT_PROD_WIDTH + $clog2(COO_NUM_OF_COLS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [FEATURE_ROWS*WEIGHT_COLS*DOT_PROD_WIDTH-1:0]
    fm_wm_in,
  input  logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_in,
  output logic [COO_BW-1:0] coo_address,
  output logic done,
  output logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0]
    max_addi_answer
);

  localparam int RW =
    (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam logic [COO_BW-1:0] LAST_EDGE =
    COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW =
    RW'(FEATURE_ROWS - 1);

  typedef logic [WEIGHT_COLS-1:0][AGG_WIDTH-1:0] agg_row_t;

  logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1]
        [DOT_PROD_WIDTH-1:0] fm;
  logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0] coo;
  logic [COO_BW-1:0] src, dst;
  logic edge_ok;

  state_t state_q, state_d;
  logic [COO_BW-1:0] edge_q, edge_d;
  logic [RW-1:0] row_q, row_d;
  agg_row_t agg_q [FEATURE_ROWS];
  agg_row_t agg_d [FEATURE_ROWS];
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] ans_q, ans_d;
  logic done_q, done_d;
  logic [MAX_ADDRESS_WIDTH-1:0] am_idx;

  assign fm  = fm_wm_in;
  assign coo = coo_in;
  assign src = coo[0];
  assign dst = coo[1];
  assign edge_ok = (32'(src) < FEATURE_ROWS) &&
                   (32'(dst) < FEATURE_ROWS);

  argmax_unit #(
    .WEIGHT_COLS       (WEIGHT_COLS),
    .AGG_WIDTH         (AGG_WIDTH),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_argmax (
    .vals_i (agg_q[row_q]),
    .idx_o  (am_idx)
  );

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    row_d   = row_q;
    agg_d   = agg_q;
    ans_d   = ans_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        agg_d  = '{default: '0};
        edge_d = '0;
        row_d  = '0;
        done_d = 1'b0;
        if (start) state_d = AGGREGATE;
      end
      AGGREGATE: begin
        if (edge_ok) begin
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              if (32'(src) == r)
                agg_d[r][c] = agg_d[r][c] +
                              AGG_WIDTH'(fm[dst][c]);
              // a self-loop contributes only once
              if (32'(dst) == r && src != dst)
                agg_d[r][c] = agg_d[r][c] +
                              AGG_WIDTH'(fm[src][c]);
            end
          end
        end
        if (edge_q == LAST_EDGE) begin
          edge_d  = '0;
          row_d   = '0;
          state_d = ARGMAX;
        end else begin
          edge_d = edge_q + 1'b1;
        end
      end
      ARGMAX: begin
        ans_d[row_q] = am_idx;
        if (row_q == LAST_ROW) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      edge_q  <= '0;
      row_q   <= '0;
      agg_q   <= '{default: '0};
      ans_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      row_q   <= row_d;
      agg_q   <= agg_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
    end
  end

  assign coo_address     = edge_q;
  assign done            = done_q;
  assign max_addi_answer = ans_q;

endmodule

// File: tb/tb_coo_aggregation.sv
// Directed bench for coo_aggregation with
// hand-computed per-node argmax answers.
module tb_coo_aggregation;

  logic clk;
  logic reset;
  logic start;
  logic [0:5][0:2][15:0] fm;
  logic [287:0] fm_wm_in;
  logic [5:0] coo_in;
  logic [2:0] coo_address;
  logic done;
  logic [11:0] max_addi_answer;

  logic [2:0] es [8];
  logic [2:0] ed [8];

  int checks;
  int errors;

  assign fm_wm_in = fm;
  assign coo_in   = {es[coo_address], ed[coo_address]};

  coo_aggregation dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .fm_wm_in        (fm_wm_in),
    .coo_in          (coo_in),
    .coo_address     (coo_address),
    .done            (done),
    .max_addi_answer (max_addi_answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_edge(input int i,
                          input logic [2:0] s,
                          input logic [2:0] d);
    es[i] = s;
    ed[i] = d;
  endtask

  task automatic ring_cfg();
    for (int i = 0; i < 6; i++)
      set_edge(i, 3'(i), 3'((i + 1) % 6));
    for (int n = 0; n < 6; n++)
      fm[n] = {16'(n), 16'd0, 16'd0};
    fm[3] = {16'd0, 16'd0, 16'd9};
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic run_case(input string tag,
                          input logic [11:0] exp);
    int n;
    logic [2:0] amax;
    n = 0;
    amax = '0;
    start = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (coo_address > amax) amax = coo_address;
      if (done) break;
    end
    chk({tag, "_lat"}, n, 1 + 12);
    chk({tag, "_ans"}, max_addi_answer, exp);
    chk({tag, "_addr"}, amax, 5);
    chk({tag, "_nox"}, $isunknown(max_addi_answer), 0);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, done, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, done, 0);
    chk({tag, "_keep"}, max_addi_answer, exp);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    fm = '0;
    for (int i = 0; i < 8; i++) set_edge(i, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_addr", coo_address, 0);
    chk("rst_ans", max_addi_answer, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    ring_cfg();
    run_case("ring", {2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0});

    for (int n = 0; n < 6; n++)
      fm[n] = {16'd5, 16'd5, 16'd5};
    set_edge(0, 3'd0, 3'd3);
    set_edge(1, 3'd1, 3'd4);
    set_edge(2, 3'd2, 3'd5);
    set_edge(3, 3'd3, 3'd3);
    set_edge(4, 3'd7, 3'd1);
    set_edge(5, 3'd5, 3'd0);
    run_case("tie", 12'd0);

    fm = '0;
    fm[2] = {16'd1, 16'd7, 16'd3};
    for (int i = 0; i < 6; i++) set_edge(i, 3'd2, 3'd2);
    run_case("self", {2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0});

    fm = '0;
    fm[0] = {16'd3, 16'd0, 16'd0};
    fm[1] = {16'd0, 16'd0, 16'd65535};
    set_edge(0, 3'd0, 3'd1);
    set_edge(1, 3'd7, 3'd0);
    set_edge(2, 3'd1, 3'd7);
    set_edge(3, 3'd0, 3'd1);
    set_edge(4, 3'd7, 3'd7);
    set_edge(5, 3'd6, 3'd1);
    run_case("oor", {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});

    fm = '0;
    fm[1] = {16'd0, 16'd0, 16'd65535};
    for (int i = 0; i < 6; i++) set_edge(i, 3'd1, 3'd0);
    run_case("rep", {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});

    // col2 of node 0 is 327675; any truncation drops it below 65535
    fm[0] = {16'd65535, 16'd0, 16'd0};
    for (int i = 0; i < 5; i++) set_edge(i, 3'd1, 3'd0);
    set_edge(5, 3'd0, 3'd0);
    run_case("wide", {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});

    ring_cfg();
    start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_done", done, 0);
    chk("mid_ans", max_addi_answer, 0);
    chk("mid_addr", coo_address, 0);
    @(negedge clk);
    reset = 1'b0;
    run_case("rerun", {2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
